gb_bus_frontend: RTL and testbench
==================================

Name: gb_bus_frontend

Overview:
- Upstream stage of the cartridge mapper.
- Brings the asynchronous Game Boy cartridge bus into the local clock domain.
- Filters glitches on /WR and decodes each qualified write into a single-cycle register-write command for the MBC register file: RAM enable, ROM bank low, ROM bank high, RAM bank, mode, and external RAM data.
- Also provides a synchronized read-active indication for downstream chip-select timing checks.

Parameters:
- SYNC_STAGES, 2: synchronizer depth applied to every bus input. Legal range 2..4. All inputs use the same depth, so address, data and strobes stay aligned.
- FILTER_CYCLES, 3: consecutive synchronized cycles /WR must stay low before a write is accepted. Legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- gb_addr_hi  input  4  bus A15..A12 (bit 3 = A15), asynchronous
- gb_data  input  8  bus D7..D0, asynchronous
- gb_write_n  input  1  bus /WR, asynchronous
- gb_read_n  input  1  bus /RD, asynchronous
- cs_n  input  1  bus /CS (external RAM window), asynchronous
- wr_valid  output  1  one-cycle write command strobe
- wr_sel  output  3  target: 1 RAM_EN, 2 ROM_LO, 3 ROM_HI, 4 RAM_BANK, 5 MODE, 6 RAM_DATA
- wr_data  output  8  data captured for the command
- rd_active  output  1  synchronized (~gb_read_n & (~A15 | ~cs_n))
- glitch_pulse  output  1  one cycle for each rejected /WR pulse

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). All registers update on the rising edge of clk.
- Synchronizer reset values:
  - gb_write_n chain and its edge-history flop reset to 0 ("asserted"), so a write in progress across reset is never accepted. /WR must be seen high before it can arm.
  - gb_read_n and cs_n chains reset to 1.
  - addr/data chains reset to 0.
- Output reset values: wr_valid=0, wr_sel=0, wr_data=0, rd_active=0, glitch_pulse=0; FSM in IDLE; filter counter 0.
- FSM states:
  - IDLE: on a falling edge of synced /WR (history=1, current=0), load counter=1.
    - FILTER_CYCLES=1: go directly to ISSUE.
    - Otherwise: go to FILTER.
  - FILTER, synced /WR low: counter++. When counter reaches FILTER_CYCLES, go to ISSUE.
  - FILTER, synced /WR high: pulse glitch_pulse for 1 cycle and return to IDLE.
  - ISSUE (1 cycle): sample the synced address and data, and decode them.
    - Decoded target nonzero: drive wr_valid=1, wr_sel and wr_data registered, visible in the next cycle.
    - Decode yields 0: no strobe.
    - Go to WAIT_REL.
  - WAIT_REL: stay until synced /WR is high, then go to IDLE. The rising edge produces no action, and exactly one command is issued per /WR pulse however long it lasts.
- Latency: let t0 be the first clk cycle with synced /WR low. The wr_valid cycle is t0+FILTER_CYCLES+1. Pin-to-sync latency is SYNC_STAGES cycles.
- Decode of synced A15..A12:
  - 000x -> 1
  - 0010 -> 2
  - 0011 -> 3
  - 010x -> 4
  - 011x -> 5
  - 101x with synced cs_n=0 -> 6
  - anything else -> 0
- wr_data and wr_sel hold their last values between strobes; only wr_valid is pulsed.
- glitch_pulse and wr_valid never assert in the same cycle.
- rd_active: registered from the synced signals, 1 cycle after sync.
- Simultaneous /RD and /WR low: both paths operate independently; no arbitration.
- rst asserted in any state: next cycle IDLE, all outputs 0. Any pending command is dropped.

Optional Feature:
- Macro: GB_BUS_STATS_EN.
- When defined, adds two output ports:
  - write_count [15:0]: increments on each wr_valid.
  - glitch_count [15:0]: increments on each glitch_pulse.
  - Both saturate at 16'hFFFF, never wrap, and reset to 0.
- When undefined, neither port nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset, then /WR low 10 cycles with A=0x2, D=0x5A -> exactly one wr_valid, wr_sel=2, wr_data=0x5A, at t0+4 (defaults); glitch_pulse stays 0.
- /WR low 2 synced cycles, A=0x0, D=0x0A, FILTER_CYCLES=3 -> no wr_valid; glitch_pulse=1 for one cycle; counter back in IDLE.
- Back-to-back writes A=0x3/D=0x01 then A=0x4/D=0x03, each /WR low 5 cycles separated by 2 high cycles -> two strobes: sel=3/data=0x01, then sel=4/data=0x03.
- /WR held low through rst assert/deassert, then released and re-asserted with A=0x6/D=0x01 -> no strobe for the first pulse; one strobe sel=5/data=0x01 for the second.
- Write to A=0xA with cs_n=0, D=0x77 -> sel=6, data=0x77. Write to A=0xA with cs_n=1 -> no strobe. /RD low with A15=0 -> rd_active=1 after SYNC_STAGES+1 cycles.
- With GB_BUS_STATS_EN: 70000 accepted writes -> write_count=0xFFFF (saturated); 3 glitches -> glitch_count=3.

Source files
------------

// File: rtl/gb_bus_frontend.sv
// gb_bus_frontend
//
// Upstream stage of the cartridge mapper. Brings the asynchronous Game Boy
// cartridge bus into the clk domain, filters glitches on /WR and turns each
// qualified write into a single-cycle register-write command for the MBC
// register file. Also produces a synchronized read-active indication.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth for every bus input (2..4)
//   FILTER_CYCLES synced /WR low cycles needed to accept a write (1..15)
//
// Optional feature (macro GB_BUS_STATS_EN): adds saturating 16-bit
// write_count / glitch_count outputs.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   gb_addr_hi[3:0] A15..A12 (async)      gb_data[7:0] D7..D0 (async)
//   gb_write_n      /WR (async)           gb_read_n    /RD (async)
//   cs_n            /CS external RAM window (async)
//   wr_valid        one-cycle command strobe
//   wr_sel[2:0]     1 RAM_EN, 2 ROM_LO, 3 ROM_HI, 4 RAM_BANK, 5 MODE, 6 RAM_DATA
//   wr_data[7:0]    data captured for the command (held between strobes)
//   rd_active       registered (~/RD & (~A15 | ~/CS)) from synced inputs
//   glitch_pulse    one cycle per rejected /WR pulse
//   write_count, glitch_count (GB_BUS_STATS_EN only)
//
// Handshake: wr_valid is a pure strobe with no ready; the register file must
// accept the command in the cycle wr_valid is high. wr_sel/wr_data are only
// meaningful in that cycle, though they hold their value afterwards.
//
// The FSM state is held in state_q (type state_t) for hierarchical binding.
module gb_bus_frontend #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gb_addr_hi,
  input  logic [7:0] gb_data,
  input  logic       gb_write_n,
  input  logic       gb_read_n,
  input  logic       cs_n,
  output logic       wr_valid,
  output logic [2:0] wr_sel,
  output logic [7:0] wr_data,
  output logic       rd_active,
  output logic       glitch_pulse
`ifdef GB_BUS_STATS_EN
  ,
  output logic [15:0] write_count,
  output logic [15:0] glitch_count
`endif
);

  localparam logic [3:0] FC = 4'(FILTER_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILTER   = 2'd1,
    ISSUE    = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  // Synchronizer chains; index 0 is the first flop, SYNC_STAGES-1 the output.
  // All inputs share one depth so address, data and strobes stay aligned.
  logic [SYNC_STAGES-1:0]      wr_n_sync;
  logic [SYNC_STAGES-1:0]      rd_n_sync;
  logic [SYNC_STAGES-1:0]      cs_n_sync;
  logic [SYNC_STAGES-1:0][3:0] addr_sync;
  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic                        wr_hist;

  logic       wr_n_s;
  logic       rd_n_s;
  logic       cs_n_s;
  logic [3:0] addr_s;
  logic [7:0] data_s;

  assign wr_n_s = wr_n_sync[SYNC_STAGES-1];
  assign rd_n_s = rd_n_sync[SYNC_STAGES-1];
  assign cs_n_s = cs_n_sync[SYNC_STAGES-1];
  assign addr_s = addr_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // /WR chain and history reset to "asserted" (0): a write already in
  // progress across reset never produces a falling edge, so /WR must be seen
  // high once before anything can arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_n_sync <= '0;
      rd_n_sync <= '1;
      cs_n_sync <= '1;
      addr_sync <= '0;
      data_sync <= '0;
      wr_hist   <= 1'b0;
    end else begin
      wr_n_sync <= {wr_n_sync[SYNC_STAGES-2:0], gb_write_n};
      rd_n_sync <= {rd_n_sync[SYNC_STAGES-2:0], gb_read_n};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], cs_n};
      addr_sync <= {addr_sync[SYNC_STAGES-2:0], gb_addr_hi};
      data_sync <= {data_sync[SYNC_STAGES-2:0], gb_data};
      wr_hist   <= wr_n_s;
    end
  end

  // Address decode of A15..A12; the external RAM window also needs /CS.
  function automatic logic [2:0] decode(input logic [3:0] a, input logic cs_n_v);
    logic [2:0] sel;
    sel = 3'd0;
    casez (a)
      4'b000?: sel = 3'd1;
      4'b0010: sel = 3'd2;
      4'b0011: sel = 3'd3;
      4'b010?: sel = 3'd4;
      4'b011?: sel = 3'd5;
      4'b101?: sel = cs_n_v ? 3'd0 : 3'd6;
      default: sel = 3'd0;
    endcase
    return sel;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_valid_d;
  logic [2:0] wr_sel_d;
  logic [7:0] wr_data_d;
  logic       glitch_d;
  logic [2:0] sel_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_valid_d = 1'b0;
    wr_sel_d   = wr_sel;
    wr_data_d  = wr_data;
    glitch_d   = 1'b0;
    sel_dec    = decode(addr_s, cs_n_s);
    case (state_q)
      IDLE: begin
        // Falling edge of synced /WR: this cycle is the first low cycle.
        if (wr_hist && !wr_n_s) begin
          cnt_d   = 4'd1;
          state_d = (FC == 4'd1) ? ISSUE : FILTER;
        end
      end
      FILTER: begin
        if (wr_n_s) begin
          glitch_d = 1'b1;
          cnt_d    = 4'd0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == FC) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (sel_dec != 3'd0) begin
          wr_valid_d = 1'b1;
          wr_sel_d   = sel_dec;
          wr_data_d  = data_s;
        end
        cnt_d   = 4'd0;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        // One command per /WR pulse regardless of its length.
        if (wr_n_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid     <= 1'b0;
      wr_sel       <= 3'd0;
      wr_data      <= 8'd0;
      glitch_pulse <= 1'b0;
      rd_active    <= 1'b0;
    end else begin
      wr_valid     <= wr_valid_d;
      wr_sel       <= wr_sel_d;
      wr_data      <= wr_data_d;
      glitch_pulse <= glitch_d;
      rd_active    <= ~rd_n_s & (~addr_s[3] | ~cs_n_s);
    end
  end

`ifdef GB_BUS_STATS_EN
  // Saturating event counters; they stick at 16'hFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_count  <= 16'd0;
      glitch_count <= 16'd0;
    end else begin
      if (wr_valid && write_count != 16'hFFFF) begin
        write_count <= write_count + 16'd1;
      end
      if (glitch_pulse && glitch_count != 16'hFFFF) begin
        glitch_count <= glitch_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gb_bus_frontend.sv
module tb_gb_bus_frontend;

  localparam int S = 2;
  localparam int F = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gb_addr_hi;
  logic [7:0] gb_data;
  logic       gb_write_n;
  logic       gb_read_n;
  logic       cs_n;
  logic       wr_valid;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic       rd_active;
  logic       glitch_pulse;
`ifdef GB_BUS_STATS_EN
  logic [15:0] write_count;
  logic [15:0] glitch_count;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gb_bus_frontend #(.SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
    .clk          (clk),
    .rst          (rst),
    .gb_addr_hi   (gb_addr_hi),
    .gb_data      (gb_data),
    .gb_write_n   (gb_write_n),
    .gb_read_n    (gb_read_n),
    .cs_n         (cs_n),
    .wr_valid     (wr_valid),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .rd_active    (rd_active),
    .glitch_pulse (glitch_pulse)
`ifdef GB_BUS_STATS_EN
    ,
    .write_count  (write_count),
    .glitch_count (glitch_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Event word: {kind(1: command, 0: glitch), cycle[19:0], sel[2:0], data[7:0]}
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [2:0]  last_sel  = 3'd0;
  logic [7:0]  last_data = 8'd0;
  int          n_writes  = 0;
  int          n_glitch  = 0;

  function automatic logic [31:0] mk(input logic kind, input int c,
                                     input logic [2:0] s, input logic [7:0] d);
    logic [19:0] c20;
    c20 = 20'(c);
    return {kind, c20, s, d};
  endfunction

  function automatic logic [2:0] ref_decode(input logic [3:0] a, input logic cs);
    int ai;
    ai = int'(a);
    if (ai <= 1)                          return 3'd1;
    if (ai == 2)                          return 3'd2;
    if (ai == 3)                          return 3'd3;
    if (ai == 4 || ai == 5)               return 3'd4;
    if (ai == 6 || ai == 7)               return 3'd5;
    if ((ai == 10 || ai == 11) && !cs)    return 3'd6;
    return 3'd0;
  endfunction

  // Read path model: rd_active after edge c reflects the pins captured at
  // edge c-S, unless reset was applied at any edge in between.
  bit rd_hist[$];
  bit rst_hist[$];
  always @(posedge clk) begin
    rd_hist.push_front(!gb_read_n && (!gb_addr_hi[3] || !cs_n));
    rst_hist.push_front(rst);
    if (rd_hist.size() > 8) begin
      void'(rd_hist.pop_back());
      void'(rst_hist.pop_back());
    end
  end

  // ---------------- monitor ----------------
  logic mon_exp_rd;
  always @(negedge clk) begin
    if (wr_valid === 1'b1)     obs_q.push_back(mk(1'b1, cyc, wr_sel, wr_data));
    if (glitch_pulse === 1'b1) obs_q.push_back(mk(1'b0, cyc, 3'd0, 8'd0));
    if (rst_hist.size() > S) begin
      mon_exp_rd = rd_hist[S];
      for (int i = 0; i <= S; i++) if (rst_hist[i]) mon_exp_rd = 1'b0;
      checks++;
      assert (rd_active === mon_exp_rd) else begin
        errors++;
        $error("FAIL rd_active cyc=%0d observed=%b expected=%b", cyc, rd_active, mon_exp_rd);
      end
    end
    checks++;
    assert ((wr_valid & glitch_pulse) === 1'b0) else begin
      errors++;
      $error("FAIL exclusive cyc=%0d observed wr_valid=%b glitch_pulse=%b expected not both",
             cyc, wr_valid, glitch_pulse);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic flush();
    logic [31:0] e;
    logic [31:0] o;
    repeat (S + F + 4) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL event observed=%h expected=%h (kind|cycle|sel|data)", o, e);
      end
    end
    checks++;
    assert (obs_q.size() == 0) else begin
      errors++;
      $error("FAIL spurious observed=%0d extra events (first %h) expected=0",
             obs_q.size(), obs_q[0]);
      obs_q.delete();
    end
    checks++;
    assert (wr_sel === last_sel && wr_data === last_data) else begin
      errors++;
      $error("FAIL hold observed=%0d/%h expected=%0d/%h", wr_sel, wr_data, last_sel, last_data);
    end
  endtask

  // ---------------- driver ----------------
  task automatic pulse(input logic [3:0] a, input logic [7:0] d, input logic cs,
                       input logic rd, input int low, input int gap);
    int         c;
    logic [2:0] s;
    gb_addr_hi = a;
    gb_data    = d;
    cs_n       = cs;
    gb_read_n  = rd;
    @(negedge clk);
    gb_write_n = 1'b0;
    c = cyc;
    if (low >= F) begin
      s = ref_decode(a, cs);
      if (s != 3'd0) begin
        exp_q.push_back(mk(1'b1, c + 1 + S + F, s, d));
        last_sel  = s;
        last_data = d;
        n_writes++;
      end
    end else begin
      exp_q.push_back(mk(1'b0, c + 1 + S + low, 3'd0, 8'd0));
      n_glitch++;
    end
    repeat (low) @(negedge clk);
    gb_write_n = 1'b1;
    repeat (gap) @(negedge clk);
    flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst        = 1'b1;
    gb_write_n = 1'b1;
    gb_read_n  = 1'b1;
    cs_n       = 1'b1;
    gb_addr_hi = 4'h0;
    gb_data    = 8'h00;
    repeat (4) @(negedge clk);

    checks++; assert (wr_valid === 1'b0)     else begin errors++; $error("FAIL rst_wr_valid observed=%b expected=0", wr_valid); end
    checks++; assert (wr_sel === 3'd0)       else begin errors++; $error("FAIL rst_wr_sel observed=%0d expected=0", wr_sel); end
    checks++; assert (wr_data === 8'h00)     else begin errors++; $error("FAIL rst_wr_data observed=%h expected=00", wr_data); end
    checks++; assert (rd_active === 1'b0)    else begin errors++; $error("FAIL rst_rd_active observed=%b expected=0", rd_active); end
    checks++; assert (glitch_pulse === 1'b0) else begin errors++; $error("FAIL rst_glitch observed=%b expected=0", glitch_pulse); end

    rst = 1'b0;
    repeat (S + 2) @(negedge clk);
    flush();

    // Long write to ROM_LO, then a short rejected pulse.
    pulse(4'h2, 8'h5A, 1'b1, 1'b1, 10, 3);
    pulse(4'h0, 8'h0A, 1'b1, 1'b1, 2, 3);
    // Back-to-back writes.
    pulse(4'h3, 8'h01, 1'b1, 1'b1, 5, 2);
    pulse(4'h4, 8'h03, 1'b1, 1'b1, 5, 2);

    // /WR held low through reset: no command; the next pulse is accepted.
    gb_addr_hi = 4'h6;
    gb_data    = 8'h01;
    @(negedge clk);
    gb_write_n = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_sel  = 3'd0;
    last_data = 8'h00;
    n_writes  = 0;
    n_glitch  = 0;
    repeat (8) @(negedge clk);
    gb_write_n = 1'b1;
    repeat (3) @(negedge clk);
    flush();
    pulse(4'h6, 8'h01, 1'b1, 1'b1, 5, 3);

    // External RAM window with and without /CS.
    pulse(4'hA, 8'h77, 1'b0, 1'b1, 4, 2);
    pulse(4'hA, 8'h88, 1'b1, 1'b1, 4, 2);
    // Exact filter length and one short of it.
    pulse(4'h1, 8'hC3, 1'b1, 1'b1, F, 2);
    pulse(4'h5, 8'h3C, 1'b1, 1'b1, F - 1, 2);

    // Directed read: /RD low with A15=0 shows up after S+1 edges.
    gb_addr_hi = 4'h0;
    gb_read_n  = 1'b0;
    repeat (S) @(negedge clk);
    checks++; assert (rd_active === 1'b0) else begin errors++; $error("FAIL rd_early observed=%b expected=0", rd_active); end
    @(negedge clk);
    checks++; assert (rd_active === 1'b1) else begin errors++; $error("FAIL rd_late observed=%b expected=1", rd_active); end
    gb_read_n = 1'b1;
    repeat (S + 2) @(negedge clk);

    // Randomized pulses against the model.
    for (int i = 0; i < 60; i++) begin
      pulse(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(1, F + 4), $urandom_range(2, 4));
    end

`ifdef GB_BUS_STATS_EN
    checks++; assert (write_count === 16'(n_writes)) else begin errors++; $error("FAIL write_count observed=%0d expected=%0d", write_count, n_writes); end
    checks++; assert (glitch_count === 16'(n_glitch)) else begin errors++; $error("FAIL glitch_count observed=%0d expected=%0d", glitch_count, n_glitch); end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
